dotmatrix_capture: RTL

- Receiving end of the dot-matrix serial display interface (RCLK/RSDI/OEB/CSDI/CCLK/LE) that the pong core drives.
- Oversamples the six display lines in the system clock domain and rebuilds the column and row shift registers and latches the panel would hold.
- Writes each displayed row into an internal frame buffer that can be read back.
- Used as a loopback monitor on the FPGA and as the scoreboard model in simulation.

---
 rtl/dotmatrix_pkg.sv | 54 +++++
 rtl/dotmatrix_capture_sync_edge.sv | 41 ++++
 rtl/dotmatrix_capture.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dotmatrix_pkg.sv
// -----------------------------------------------------------------------------
// dotmatrix_pkg
//
// Shared definitions for the dot-matrix display capture block:
//   - default panel geometry (COLS_DEF column bits, ROWS_DEF row-select bits)
//   - write state machine encoding (IDLE, ARMED, WRITE)
//   - one-hot to index decoder that also reports whether the word was one-hot
//
// The decoder works on a fixed 32-bit vector so it can serve any panel of up
// to 32 rows; callers zero-extend their row word into it.
// -----------------------------------------------------------------------------
package dotmatrix_pkg;

    localparam int COLS_DEF     = 16;
    localparam int ROWS_DEF     = 8;

    // Widest row-select word the decoder understands, and its index width.
    localparam int ONEHOT_MAX   = 32;
    localparam int ONEHOT_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a latch pulse
        ARMED = 2'd1,   // latches hold a fresh row, waiting for OEB low
        WRITE = 2'd2    // single cycle: commit the latched row to the buffer
    } wr_state_t;

    typedef struct packed {
        logic                    valid;  // exactly one bit was set
        logic [ONEHOT_IDX_W-1:0] idx;    // position of the (highest) set bit
    } onehot_dec_t;

    // Returns the bit position of a one-hot word together with a flag that is
    // only true when exactly one bit is set (zero and multi-hot are invalid).
    function automatic onehot_dec_t onehot_decode(input logic [ONEHOT_MAX-1:0] vec);
        onehot_dec_t res;
        logic        seen;
        logic        multi;
        res   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            if (vec[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen    = 1'b1;
                res.idx = ONEHOT_IDX_W'(i);
            end
        end
        res.valid = seen & ~multi;
        return res;
    endfunction

endpackage

// File: rtl/dotmatrix_capture_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//
// Two-flop synchroniser for one asynchronous input, followed by a history flop
// that produces a single-cycle pulse on each rising edge of the synchronised
// signal. A level change on din shows up on dout two clocks later, and the
// rise pulse is acted upon by downstream logic on the third clock.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset (all flops cleared)
//   din    in   asynchronous input line
//   dout   out  synchronised level
//   rise   out  one-cycle pulse, high while dout=1 and previous dout=0
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            dout <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
            prev <= dout;
        end
    end

    assign rise = dout & ~prev;

endmodule

// File: rtl/dotmatrix_capture.sv
// -----------------------------------------------------------------------------
// dotmatrix_capture
//
// Receiving end of the dot-matrix serial display interface. The six display
// lines are oversampled in the clk domain; the column and row shift registers
// and output latches of the panel are rebuilt, and every row that the panel
// would display (latched, then OEB low) is written into a frame buffer that
// can be read back. Serves as a loopback monitor and as a scoreboard model.
//
// Parameters:
//   COLS   column bits per row (CSDI chain length)
//   ROWS   one-hot row-select bits (RSDI chain length), at most 32
//   ROW_W  width of row index / read address
//
// Ports:
//   clk           in   system clock, at least 4x CCLK/RCLK
//   reset         in   asynchronous active-low reset
//   RCLK          in   row shift clock (asynchronous)
//   RSDI          in   row serial data
//   OEB           in   output enable, active low
//   CSDI          in   column serial data
//   CCLK          in   column shift clock (asynchronous)
//   LE            in   latch enable, latches both shift registers on rise
//   rd_addr       in   frame buffer read row
//   rd_data       out  frame buffer row contents, 1-cycle read latency
//   row_strobe    out  one-cycle pulse when a row has been written
//   row_idx       out  index of the last written row
//   frame_strobe  out  pulse with row_strobe when the row index wrapped down
//   sel_error     out  sticky: a displayed row word was not one-hot
//
// Build option DOTMATRIX_CAPTURE_STATS_EN adds:
//   frame_count   out  16-bit wrapping count of frame_strobe pulses
//   err_count     out  8-bit saturating count of bad row-select events
// -----------------------------------------------------------------------------
module dotmatrix_capture
    import dotmatrix_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RCLK,
    input  logic             RSDI,
    input  logic             OEB,
    input  logic             CSDI,
    input  logic             CCLK,
    input  logic             LE,
    input  logic [ROW_W-1:0] rd_addr,
    output logic [COLS-1:0]  rd_data,
    output logic             row_strobe,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_strobe,
`ifdef DOTMATRIX_CAPTURE_STATS_EN
    output logic [15:0]      frame_count,
    output logic [7:0]       err_count,
`endif
    output logic             sel_error
);

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic cclk_s, cclk_rise;
    logic rclk_s, rclk_rise;
    logic le_s,   le_rise;
    logic oeb_s,  oeb_rise;
    logic csdi_s, csdi_rise;
    logic rsdi_s, rsdi_rise;

    sync_edge u_sync_cclk (.clk(clk), .reset(reset), .din(CCLK), .dout(cclk_s), .rise(cclk_rise));
    sync_edge u_sync_rclk (.clk(clk), .reset(reset), .din(RCLK), .dout(rclk_s), .rise(rclk_rise));
    sync_edge u_sync_le   (.clk(clk), .reset(reset), .din(LE),   .dout(le_s),   .rise(le_rise));
    sync_edge u_sync_oeb  (.clk(clk), .reset(reset), .din(OEB),  .dout(oeb_s),  .rise(oeb_rise));
    sync_edge u_sync_csdi (.clk(clk), .reset(reset), .din(CSDI), .dout(csdi_s), .rise(csdi_rise));
    sync_edge u_sync_rsdi (.clk(clk), .reset(reset), .din(RSDI), .dout(rsdi_s), .rise(rsdi_rise));

    // Clock lines only need their edge, data lines only their level.
    logic unused_sync;
    assign unused_sync = &{1'b0, cclk_s, rclk_s, le_s, oeb_rise, csdi_rise, rsdi_rise};

    // -------------------------------------------------------------------------
    // Panel shift registers and latches
    // -------------------------------------------------------------------------
    logic [COLS-1:0] col_sr;
    logic [COLS-1:0] col_lat;
    logic [ROWS-1:0] row_sr;
    logic [ROWS-1:0] row_lat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_sr  <= '0;
            row_sr  <= '0;
            col_lat <= '0;
            row_lat <= '0;
        end else begin
            // NOTE: non-blocking assignments make a latch pulse that coincides
            // with a shift pulse capture the pre-shift register value, exactly
            // like the real panel; blocking here would latch the shifted word.
            if (cclk_rise) begin
                col_sr <= {col_sr[COLS-2:0], csdi_s};
            end
            if (rclk_rise) begin
                row_sr <= {row_sr[ROWS-2:0], rsdi_s};
            end
            if (le_rise) begin
                col_lat <= col_sr;
                row_lat <= row_sr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Row select decode
    // -------------------------------------------------------------------------
    onehot_dec_t      row_dec;
    logic             row_ok;
    logic [ROW_W-1:0] wr_idx;

    assign row_dec = onehot_decode(ONEHOT_MAX'(row_lat));
    // The range test also covers decoder index bits above ROW_W.
    assign row_ok  = row_dec.valid && (int'(row_dec.idx) < ROWS);
    assign wr_idx  = row_dec.idx[ROW_W-1:0];

    // -------------------------------------------------------------------------
    // Write state machine
    // -------------------------------------------------------------------------
    wr_state_t state_q;
    wr_state_t state_d;
    logic      do_write;
    logic      bad_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        do_write = 1'b0;
        bad_sel  = 1'b0;
        case (state_q)
            IDLE: begin
                if (le_rise) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A fresh latch pulse just re-latches; the write waits for OEB.
                if (le_rise) begin
                    state_d = ARMED;
                end else if (!oeb_s) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (row_ok) begin
                    do_write = 1'b1;
                end else begin
                    bad_sel = 1'b1;
                end
                // A latch pulse landing on the write cycle must not be lost
                // when OEB is held low across consecutive rows.
                state_d = le_rise ? ARMED : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame buffer and read port
    // -------------------------------------------------------------------------
    logic [COLS-1:0] fb [ROWS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the buffer must read back as zero after reset, so it is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < ROWS; i++) begin
                fb[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (do_write) begin
                fb[wr_idx] <= col_lat;
            end
            // Same-cycle read of the row being written returns the old word.
            rd_data <= fb[rd_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_strobe   <= 1'b0;
            frame_strobe <= 1'b0;
            row_idx      <= '0;
            sel_error    <= 1'b0;
        end else begin
            row_strobe   <= do_write;
            // A row index lower than the previous one means a new frame began.
            frame_strobe <= do_write && (wr_idx < row_idx);
            if (do_write) begin
                row_idx <= wr_idx;
            end
            if (bad_sel) begin
                sel_error <= 1'b1;
            end
        end
    end

`ifdef DOTMATRIX_CAPTURE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (frame_strobe) begin
                frame_count <= frame_count + 16'd1;
            end
            if (bad_sel && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule
